// File: rtl/msdap_pkg.sv
// Shared constants and FSM state encoding for the MSDAP input controller.
`timescale 1ns/1ps
package msdap_pkg;
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    READ_RJ    = 3'd1,
    READ_COEFF = 3'd2,
    WORKING    = 3'd3,
    SLEEPING   = 3'd4,
    CLEARING   = 3'd5
  } state_t;

  localparam int NUM_RJ      = 16;
  localparam int NUM_COEFF   = 512;
  localparam int DATA_DEPTH  = 256;
  localparam int SLEEP_COUNT = 800;

  localparam int WORD_W   = 16;
  localparam int RJ_AW    = 4;
  localparam int COEFF_AW = 9;
  localparam int DATA_AW  = 8;
endpackage

// File: rtl/msdap_sleep_detect.sv
// Counts consecutive zero data words and raises sleep when the run reaches SLEEP_COUNT.
`timescale 1ns/1ps
module msdap_sleep_detect import msdap_pkg::*; #(
  parameter int SLEEP_COUNT = msdap_pkg::SLEEP_COUNT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [WORD_W-1:0] word,
  output logic              hit,
  output logic              sleep
);
  localparam int ZW = $clog2(SLEEP_COUNT + 1);

  logic [ZW-1:0] zero_cnt;
  logic          zero;

  assign zero = (word == '0);
  // hit marks the word that completes the run; the caller still writes it
  assign hit  = zero && (zero_cnt == ZW'(SLEEP_COUNT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zero_cnt <= '0;
      sleep    <= 1'b0;
    end else if (clr) begin
      zero_cnt <= '0;
      sleep    <= 1'b0;
    end else if (en) begin
      if (!zero) begin
        zero_cnt <= '0;
        sleep    <= 1'b0;
      end else begin
        if (zero_cnt != ZW'(SLEEP_COUNT)) zero_cnt <= zero_cnt + 1'b1;
        if (hit) sleep <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/msdap_ctrl.sv
// MSDAP controller: loads Rj/coefficients, streams samples into a circular buffer,
// handles zero-run sleep, compute handshaking with overrun detection, and buffer clear.
`timescale 1ns/1ps
module msdap_ctrl import msdap_pkg::*; #(
  parameter int NUM_RJ      = msdap_pkg::NUM_RJ,
  parameter int NUM_COEFF   = msdap_pkg::NUM_COEFF,
  parameter int DATA_DEPTH  = msdap_pkg::DATA_DEPTH,
  parameter int SLEEP_COUNT = msdap_pkg::SLEEP_COUNT
) (
  input  logic                sClk,
  input  logic                reset,
  input  logic                start,
  input  logic                softClear,
  input  logic                wordValid,
  input  logic [WORD_W-1:0]   wordIn,
  input  logic                computeDone,
  output logic                rjWe,
  output logic [RJ_AW-1:0]    rjAddr,
  output logic                coeffWe,
  output logic [COEFF_AW-1:0] coeffAddr,
  output logic                dataWe,
  output logic [DATA_AW-1:0]  dataAddr,
  output logic [WORD_W-1:0]   wrData,
  output logic                inReady,
  output logic                computeStart,
  output logic                sleep,
  output logic                overrun,
  output logic [2:0]          state
);
  localparam int CNT_W = $clog2(NUM_COEFF > NUM_RJ ? NUM_COEFF : NUM_RJ);
  localparam int CLR_W = $clog2(DATA_DEPTH + 1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt, cnt_d;
  logic [DATA_AW-1:0]  wr_ptr, wr_ptr_d;
  logic [CLR_W-1:0]    clr_cnt, clr_cnt_d;
  logic                busy, busy_d, cs_pend, cs_pend_d;
  logic                rjWe_d, coeffWe_d, dataWe_d, inReady_d, computeStart_d, overrun_d;
  logic [RJ_AW-1:0]    rjAddr_d;
  logic [COEFF_AW-1:0] coeffAddr_d;
  logic [DATA_AW-1:0]  dataAddr_d;
  logic [WORD_W-1:0]   wrData_d;
  logic                sd_en, sd_clr, sd_hit;

  msdap_sleep_detect #(.SLEEP_COUNT(SLEEP_COUNT)) u_sleep (
    .clk(sClk), .rst(reset), .clr(sd_clr), .en(sd_en),
    .word(wordIn), .hit(sd_hit), .sleep(sleep)
  );

  assign state = state_q;

  always_ff @(posedge sClk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt          <= '0;
      wr_ptr       <= '0;
      clr_cnt      <= '0;
      busy         <= 1'b0;
      cs_pend      <= 1'b0;
      rjWe         <= 1'b0;
      rjAddr       <= '0;
      coeffWe      <= 1'b0;
      coeffAddr    <= '0;
      dataWe       <= 1'b0;
      dataAddr     <= '0;
      wrData       <= '0;
      inReady      <= 1'b0;
      computeStart <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt          <= cnt_d;
      wr_ptr       <= wr_ptr_d;
      clr_cnt      <= clr_cnt_d;
      busy         <= busy_d;
      cs_pend      <= cs_pend_d;
      rjWe         <= rjWe_d;
      rjAddr       <= rjAddr_d;
      coeffWe      <= coeffWe_d;
      coeffAddr    <= coeffAddr_d;
      dataWe       <= dataWe_d;
      dataAddr     <= dataAddr_d;
      wrData       <= wrData_d;
      inReady      <= inReady_d;
      computeStart <= computeStart_d;
      overrun      <= overrun_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt;
    wr_ptr_d       = wr_ptr;
    clr_cnt_d      = clr_cnt;
    cs_pend_d      = 1'b0;
    rjWe_d         = 1'b0;
    rjAddr_d       = rjAddr;
    coeffWe_d      = 1'b0;
    coeffAddr_d    = coeffAddr;
    dataWe_d       = 1'b0;
    dataAddr_d     = dataAddr;
    wrData_d       = wrData;
    computeStart_d = 1'b0;
    overrun_d      = overrun;
    sd_en          = 1'b0;
    sd_clr         = 1'b0;
    // busy_d is the value busy holds during the cycle a new computeStart would be out
    busy_d         = computeStart ? 1'b1 : (computeDone ? 1'b0 : busy);

    case (state_q)
      IDLE: if (start) begin
        state_d = READ_RJ;
        cnt_d   = '0;
      end
      READ_RJ: if (wordValid) begin
        rjWe_d   = 1'b1;
        rjAddr_d = RJ_AW'(cnt);
        wrData_d = wordIn;
        if (cnt == CNT_W'(NUM_RJ - 1)) begin
          state_d = READ_COEFF;
          cnt_d   = '0;
        end else cnt_d = cnt + 1'b1;
      end
      READ_COEFF: if (wordValid) begin
        coeffWe_d   = 1'b1;
        coeffAddr_d = COEFF_AW'(cnt);
        wrData_d    = wordIn;
        if (cnt == CNT_W'(NUM_COEFF - 1)) begin
          state_d = WORKING;
          cnt_d   = '0;
        end else cnt_d = cnt + 1'b1;
      end
      WORKING, SLEEPING: begin
        if (softClear) begin
          state_d   = CLEARING;
          wr_ptr_d  = '0;
          clr_cnt_d = '0;
          busy_d    = 1'b0;
          overrun_d = 1'b0;
          sd_clr    = 1'b1;
        end else begin
          if (cs_pend) begin
            if (busy_d) overrun_d = 1'b1;
            else        computeStart_d = 1'b1;
          end
          // zeros arriving while asleep are discarded outright
          if (wordValid && !(state_q == SLEEPING && wordIn == '0)) begin
            dataWe_d   = 1'b1;
            dataAddr_d = wr_ptr;
            wrData_d   = wordIn;
            wr_ptr_d   = (wr_ptr == DATA_AW'(DATA_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            cs_pend_d  = 1'b1;
            sd_en      = 1'b1;
            if (sd_hit)                     state_d = SLEEPING;
            else if (state_q == SLEEPING)   state_d = WORKING;
          end
        end
      end
      CLEARING: begin
        if (clr_cnt != CLR_W'(DATA_DEPTH)) begin
          dataWe_d   = 1'b1;
          dataAddr_d = DATA_AW'(clr_cnt);
          wrData_d   = '0;
          clr_cnt_d  = clr_cnt + 1'b1;
        end else if (!softClear) state_d = WORKING;
      end
      default: state_d = IDLE;
    endcase

    inReady_d = (state_d == READ_RJ) || (state_d == READ_COEFF) ||
                (state_d == WORKING) || (state_d == SLEEPING);
  end
endmodule

// File: tb/tb_msdap_ctrl.sv
// Directed bench for msdap_ctrl: load, wrap, sleep, overrun, clear and reset scenarios.
`timescale 1ns/1ps
module tb_msdap_ctrl;
  logic        sClk = 1'b0;
  logic        reset, start, softClear, wordValid, computeDone;
  logic [15:0] wordIn;
  logic        rjWe, coeffWe, dataWe, inReady, computeStart, sleep, overrun;
  logic [3:0]  rjAddr;
  logic [8:0]  coeffAddr;
  logic [7:0]  dataAddr;
  logic [15:0] wrData;
  logic [2:0]  state;

  int total = 0;
  int bad   = 0;

  msdap_ctrl dut (
    .sClk(sClk), .reset(reset), .start(start), .softClear(softClear),
    .wordValid(wordValid), .wordIn(wordIn), .computeDone(computeDone),
    .rjWe(rjWe), .rjAddr(rjAddr), .coeffWe(coeffWe), .coeffAddr(coeffAddr),
    .dataWe(dataWe), .dataAddr(dataAddr), .wrData(wrData), .inReady(inReady),
    .computeStart(computeStart), .sleep(sleep), .overrun(overrun), .state(state)
  );

  always #5 sClk = ~sClk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected $finish before 1ms");
    $fatal(1);
  end

  task automatic step;
    @(posedge sClk); #1;
  endtask

  task automatic send_word(input logic [15:0] w);
    wordValid = 1'b1; wordIn = w;
    step();
    wordValid = 1'b0;
  endtask

  task automatic done_handshake;
    step();
    computeDone = 1'b1;
    step();
    computeDone = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 0; softClear = 0; wordValid = 0; computeDone = 0; wordIn = '0;
    step();
    total++;
    if ({rjWe, coeffWe, dataWe, inReady, computeStart, sleep, overrun} !== 7'b0) begin
      bad++; $display("FAIL reset_flags: got %b expected 0000000",
                      {rjWe, coeffWe, dataWe, inReady, computeStart, sleep, overrun});
    end
    total++;
    if (state !== 3'd0 || rjAddr !== 4'd0 || coeffAddr !== 9'd0 || dataAddr !== 8'd0 || wrData !== 16'd0) begin
      bad++; $display("FAIL reset_regs: state=%0d rjA=%0d cA=%0d dA=%0d wd=%h expected all 0",
                      state, rjAddr, coeffAddr, dataAddr, wrData);
    end
    reset = 1'b0;
    send_word(16'h5555);
    total++;
    if (state !== 3'd0 || rjWe !== 1'b0 || inReady !== 1'b0) begin
      bad++; $display("FAIL idle_ignore: state=%0d rjWe=%b inReady=%b expected 0 0 0", state, rjWe, inReady);
    end
  endtask

  task automatic test_load;
    logic [15:0] exp;
    start = 1'b1; step(); start = 1'b0;
    total++;
    if (state !== 3'd1 || inReady !== 1'b1) begin
      bad++; $display("FAIL start: state=%0d inReady=%b expected 1 1", state, inReady);
    end
    for (int i = 0; i < 16; i++) begin
      exp = 16'hA000 + 16'(i);
      send_word(exp);
      total++;
      if (rjWe !== 1'b1 || rjAddr !== 4'(i) || wrData !== exp || coeffWe !== 1'b0) begin
        bad++; $display("FAIL rj_write%0d: we=%b addr=%0d data=%h expected we=1 addr=%0d data=%h",
                        i, rjWe, rjAddr, wrData, i, exp);
      end
    end
    total++;
    if (state !== 3'd2) begin bad++; $display("FAIL rj_done: state=%0d expected 2", state); end
    for (int i = 0; i < 512; i++) begin
      exp = 16'hC000 + 16'(i);
      send_word(exp);
      total++;
      if (coeffWe !== 1'b1 || coeffAddr !== 9'(i) || wrData !== exp || rjWe !== 1'b0) begin
        bad++; $display("FAIL coeff_write%0d: we=%b addr=%0d data=%h expected we=1 addr=%0d data=%h",
                        i, coeffWe, coeffAddr, wrData, i, exp);
      end
    end
    total++;
    if (state !== 3'd3 || inReady !== 1'b1) begin
      bad++; $display("FAIL load_done: state=%0d inReady=%b expected 3 1", state, inReady);
    end
  endtask

  task automatic test_wrap;
    int ncs = 0;
    for (int i = 0; i < 257; i++) begin
      start = (i == 0);
      send_word(16'(i + 1));
      start = 1'b0;
      total++;
      if (dataWe !== 1'b1 || dataAddr !== 8'(i % 256) || wrData !== 16'(i + 1) || state !== 3'd3) begin
        bad++; $display("FAIL wrap_write%0d: we=%b addr=%0d data=%h state=%0d expected 1 %0d %h 3",
                        i, dataWe, dataAddr, wrData, state, i % 256, i + 1);
      end
      step();
      if (computeStart === 1'b1) ncs++;
      done_handshake();
    end
    total++;
    if (ncs !== 257 || overrun !== 1'b0) begin
      bad++; $display("FAIL wrap_compute: pulses=%0d overrun=%b expected 257 0", ncs, overrun);
    end
  endtask

  task automatic test_sleep;
    int ncs = 0;
    for (int i = 0; i < 800; i++) begin
      send_word(16'h0000);
      total++;
      if (dataWe !== 1'b1 || sleep !== (i == 799) || state !== ((i == 799) ? 3'd4 : 3'd3)) begin
        bad++; $display("FAIL zero_write%0d: we=%b sleep=%b state=%0d expected 1 %b %0d",
                        i, dataWe, sleep, state, i == 799, (i == 799) ? 4 : 3);
      end
      step();
      if (computeStart === 1'b1) ncs++;
      done_handshake();
    end
    total++;
    if (ncs !== 800 || inReady !== 1'b1) begin
      bad++; $display("FAIL sleep_entry: pulses=%0d inReady=%b expected 800 1", ncs, inReady);
    end
    for (int i = 0; i < 5; i++) begin
      send_word(16'h0000);
      total++;
      if (dataWe !== 1'b0 || state !== 3'd4) begin
        bad++; $display("FAIL sleep_discard%0d: we=%b state=%0d expected 0 4", i, dataWe, state);
      end
      step();
      total++;
      if (computeStart !== 1'b0) begin
        bad++; $display("FAIL sleep_nocompute%0d: cs=%b expected 0", i, computeStart);
      end
    end
    send_word(16'h0001);
    total++;
    if (dataWe !== 1'b1 || dataAddr !== 8'd33 || wrData !== 16'h0001 || state !== 3'd3 || sleep !== 1'b0) begin
      bad++; $display("FAIL wake: we=%b addr=%0d data=%h state=%0d sleep=%b expected 1 33 0001 3 0",
                      dataWe, dataAddr, wrData, state, sleep);
    end
    step();
    total++;
    if (computeStart !== 1'b1) begin bad++; $display("FAIL wake_compute: cs=%b expected 1", computeStart); end
    done_handshake();
  endtask

  task automatic test_overrun;
    send_word(16'h0005);
    send_word(16'h0006);
    total++;
    if (dataWe !== 1'b1 || dataAddr !== 8'd35 || computeStart !== 1'b1) begin
      bad++; $display("FAIL overrun_second: we=%b addr=%0d cs=%b expected 1 35 1", dataWe, dataAddr, computeStart);
    end
    step();
    total++;
    if (computeStart !== 1'b0 || overrun !== 1'b1) begin
      bad++; $display("FAIL overrun_flag: cs=%b overrun=%b expected 0 1", computeStart, overrun);
    end
    send_word(16'h0007);
    total++;
    if (dataAddr !== 8'd36) begin bad++; $display("FAIL overrun_ptr: addr=%0d expected 36", dataAddr); end
    step();
    total++;
    if (computeStart !== 1'b0 || overrun !== 1'b1) begin
      bad++; $display("FAIL overrun_sticky: cs=%b overrun=%b expected 0 1", computeStart, overrun);
    end
  endtask

  task automatic test_clear;
    softClear = 1'b1; step(); softClear = 1'b0;
    total++;
    if (state !== 3'd5 || inReady !== 1'b0 || overrun !== 1'b0 || sleep !== 1'b0 || dataWe !== 1'b0) begin
      bad++; $display("FAIL clear_entry: state=%0d inReady=%b overrun=%b sleep=%b we=%b expected 5 0 0 0 0",
                      state, inReady, overrun, sleep, dataWe);
    end
    for (int k = 0; k < 256; k++) begin
      step();
      total++;
      if (dataWe !== 1'b1 || dataAddr !== 8'(k) || wrData !== 16'h0 || inReady !== 1'b0) begin
        bad++; $display("FAIL clear_write%0d: we=%b addr=%0d data=%h inReady=%b expected 1 %0d 0000 0",
                        k, dataWe, dataAddr, wrData, inReady, k);
      end
    end
    step();
    total++;
    if (state !== 3'd3 || inReady !== 1'b1 || dataWe !== 1'b0) begin
      bad++; $display("FAIL clear_exit: state=%0d inReady=%b we=%b expected 3 1 0", state, inReady, dataWe);
    end
    send_word(16'h0009);
    total++;
    if (dataWe !== 1'b1 || dataAddr !== 8'd0) begin
      bad++; $display("FAIL clear_ptr: we=%b addr=%0d expected 1 0", dataWe, dataAddr);
    end
    step();
    total++;
    if (computeStart !== 1'b1) begin bad++; $display("FAIL clear_busy: cs=%b expected 1", computeStart); end
    done_handshake();
  endtask

  task automatic test_clear_hold;
    softClear = 1'b1; wordValid = 1'b1; wordIn = 16'h0077;
    step();
    wordValid = 1'b0;
    total++;
    if (state !== 3'd5 || dataWe !== 1'b0) begin
      bad++; $display("FAIL clear_drop: state=%0d we=%b expected 5 0", state, dataWe);
    end
    for (int k = 0; k < 256; k++) step();
    for (int k = 0; k < 2; k++) begin
      step();
      total++;
      if (state !== 3'd5 || dataWe !== 1'b0) begin
        bad++; $display("FAIL clear_hold%0d: state=%0d we=%b expected 5 0", k, state, dataWe);
      end
    end
    softClear = 1'b0;
    step();
    total++;
    if (state !== 3'd3) begin bad++; $display("FAIL clear_release: state=%0d expected 3", state); end
  endtask

  task automatic test_reset_midload;
    reset = 1'b1; step(); reset = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 16; i++) send_word(16'hB000 + 16'(i));
    for (int i = 0; i < 100; i++) send_word(16'hD000 + 16'(i));
    total++;
    if (state !== 3'd2 || coeffAddr !== 9'd99 || wrData !== 16'hD063) begin
      bad++; $display("FAIL midload: state=%0d addr=%0d data=%h expected 2 99 d063", state, coeffAddr, wrData);
    end
    reset = 1'b1;
    #1;
    total++;
    if (state !== 3'd0 || coeffWe !== 1'b0 || coeffAddr !== 9'd0 || wrData !== 16'd0 ||
        inReady !== 1'b0 || rjAddr !== 4'd0) begin
      bad++; $display("FAIL async_reset: state=%0d cWe=%b cA=%0d wd=%h inReady=%b rjA=%0d expected all 0",
                      state, coeffWe, coeffAddr, wrData, inReady, rjAddr);
    end
    step(); reset = 1'b0; step();
    start = 1'b1; step(); start = 1'b0;
    send_word(16'h1234);
    total++;
    if (state !== 3'd1 || rjWe !== 1'b1 || rjAddr !== 4'd0 || wrData !== 16'h1234) begin
      bad++; $display("FAIL reload: state=%0d we=%b addr=%0d data=%h expected 1 1 0 1234",
                      state, rjWe, rjAddr, wrData);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_wrap();
    test_sleep();
    test_overrun();
    test_clear();
    test_clear_hold();
    test_reset_midload();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
